if_fetch_queue: RTL



---
 rtl/if_fetch_queue_if.sv | 47 ++++
 rtl/if_fetch_queue.sv | 122 ++++++++++++
 2 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue port bundle: decode handshake, branch redirect, instruction
// SRAM request/response and debug taps. The fetch stage uses the master
// view; the surrounding pipeline/SRAM uses the slave view.
interface if_fetch_queue_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 3
);
    logic                ds_allowin;
    logic [XLEN:0]       br_bus;
    logic                inst_sram_ready;
    logic [31:0]         inst_sram_rdata;
    logic                inst_sram_en;
    logic [XLEN-1:0]     inst_sram_addr;
    logic                fs_to_ds_valid;
    logic [XLEN+31:0]    fs_to_ds_bus;
    logic [CNT_W-1:0]    fq_count;
    logic [XLEN-1:0]     debug_nextpc;
    logic [31:0]         debug_if_inst;

    modport master (
        input  ds_allowin,
        input  br_bus,
        input  inst_sram_ready,
        input  inst_sram_rdata,
        output inst_sram_en,
        output inst_sram_addr,
        output fs_to_ds_valid,
        output fs_to_ds_bus,
        output fq_count,
        output debug_nextpc,
        output debug_if_inst
    );

    modport slave (
        output ds_allowin,
        output br_bus,
        output inst_sram_ready,
        output inst_sram_rdata,
        input  inst_sram_en,
        input  inst_sram_addr,
        input  fs_to_ds_valid,
        input  fs_to_ds_bus,
        input  fq_count,
        input  debug_nextpc,
        input  debug_if_inst
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Queued instruction-fetch stage. Issues PC-stream requests to a 1-cycle
// latency instruction SRAM, buffers returned instructions in a DEPTH-entry
// FIFO so fetch runs ahead of a stalled decode, and redirects on a taken
// branch with zero bubble by flushing the queue and the in-flight response.
module if_fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(64'h0000_0000_8000_0000),
    parameter int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            resetn,
    if_fetch_queue_if.master bus
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(DEPTH);

    logic                  br_taken;
    logic [XLEN-1:0]       br_target;

    logic [XLEN-1:0]       fetch_pc;
    logic [XLEN-1:0]       req_pc;
    logic                  inflight;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic [XLEN-1:0]       pc_q   [DEPTH];
    logic [31:0]           inst_q [DEPTH];

    logic [CNT_W:0]        occupancy;
    logic                  issue;
    logic [XLEN-1:0]       fetch_addr;
    logic                  head_valid;
    logic                  accept;
    logic                  pop;
    logic                  write_en;

    assign br_taken  = bus.br_bus[XLEN];
    assign br_target = bus.br_bus[XLEN-1:0];

    // Issue, redirect and handshake decisions for the current cycle.
    // Capacity counts queued entries plus the response still in flight and
    // deliberately ignores a same-cycle pop; a taken branch always issues
    // because it empties the queue in the same cycle.
    always_comb begin
        occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue      = resetn & (br_taken | (occupancy < DEPTH_W));
        fetch_addr = br_taken ? br_target : fetch_pc;
        head_valid = (count != '0) & ~br_taken;
        accept     = issue & bus.inst_sram_ready;
        pop        = head_valid & bus.ds_allowin;
        write_en   = inflight & ~br_taken;
    end

    // PC sequencing and in-flight tracking; a stalled SRAM keeps the address
    // stable, while a branch that is not accepted is remembered in fetch_pc.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= PC_RESET;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                req_pc   <= fetch_addr;
                fetch_pc <= fetch_addr + XLEN'(4);
            end else if (br_taken) begin
                fetch_pc <= br_target;
            end
        end
    end

    // Occupancy counter; a branch flushes, otherwise write and pop net out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (br_taken) begin
            count <= '0;
        end else if (write_en && !pop) begin
            count <= count + CNT_W'(1);
        end else if (pop && !write_en) begin
            count <= count - CNT_W'(1);
        end
    end

    // Queue pointers; power-of-two depth lets them wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (br_taken) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Queue storage, written with the response of last cycle's request.
    always_ff @(posedge clk) begin
        if (write_en) begin
            pc_q[wr_ptr]   <= req_pc;
            inst_q[wr_ptr] <= bus.inst_sram_rdata;
        end
    end

    assign bus.inst_sram_en   = issue;
    assign bus.inst_sram_addr = fetch_addr;
    assign bus.debug_nextpc   = fetch_addr;
    assign bus.fs_to_ds_valid = head_valid;
    assign bus.fs_to_ds_bus   = {pc_q[rd_ptr], inst_q[rd_ptr]};
    assign bus.debug_if_inst  = inst_q[rd_ptr];
    assign bus.fq_count       = count;

endmodule
